// File: rtl/keypad_pkg.sv
//==================================================================
// keypad_pkg -- shared types and constants for the keypad scanner. Rev 1.0
//==================================================================
`default_nettype none

package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ROW_W = 2;

    localparam logic [COLS-1:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Lowest-index active-low row wins when several rows are down.
    function automatic logic [ROW_W-1:0] first_low(input logic [ROWS-1:0] rows_n);
        first_low = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) begin
                first_low = ROW_W'(i);
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/row_sync.sv
//==================================================================
// row_sync -- 2-flop synchronizer, resets to all ones (idle rows). Rev 1.0
//==================================================================
`default_nettype none

module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
//==================================================================
// keypad_scan -- 4x4 matrix keypad scanner with press/release debounce. Rev 1.0
//==================================================================
`default_nettype none

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  row_n,
    output logic [COLS-1:0]  col_n,
    output logic             pressed,
    output logic [KEY_W-1:0] key,
    output logic             key_valid
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [ROWS-1:0] row_s;

    row_sync #(
        .WIDTH (ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_s)
    );

    state_t             state_q,     state_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [1:0]         col_idx_q,   col_idx_d;
    logic [ROW_W-1:0]   cand_row_q,  cand_row_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               pressed_q,   pressed_d;
    logic [KEY_W-1:0]   key_q,       key_d;
    logic               key_valid_q, key_valid_d;
    logic [COLS-1:0]    col_n_q,     col_n_d;

    logic tick;
    logic any_low;
    logic row_hit;

    assign tick    = (div_q == DIV_LAST);
    assign any_low = ~&row_s;
    assign row_hit = ~row_s[cand_row_q];

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        col_idx_d   = col_idx_q;
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        pressed_d   = pressed_q;
        key_d       = key_q;
        key_valid_d = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        cand_row_d = first_low(row_s);
                        cnt_d      = '0;
                        state_d    = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_hit) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d     = HELD;
                            key_d       = {cand_row_q, col_idx_q};
                            pressed_d   = 1'b1;
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        // A single high sample already satisfies a debounce count of one.
                        if (DEBOUNCE_CNT == 1) begin
                            pressed_d = 1'b0;
                            state_d   = SCAN;
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!row_hit) begin
                        if (cnt_q == CNT_LAST) begin
                            pressed_d = 1'b0;
                            state_d   = SCAN;
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end

        col_n_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            div_q       <= '0;
            col_idx_q   <= '0;
            cand_row_q  <= '0;
            cnt_q       <= '0;
            pressed_q   <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            col_n_q     <= COL_IDLE;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            pressed_q   <= pressed_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            col_n_q     <= col_n_d;
        end
    end

    assign col_n     = col_n_q;
    assign pressed   = pressed_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;

endmodule

`default_nettype wire
